// File: rtl/pp_ctrl_pkg.sv
// rtl/pp_ctrl_pkg.sv - shared types and defaults for the ping-pong buffer front end
package pp_ctrl_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_RISE,
    DB_HELD,
    DB_FALL
  } db_state_t;

  localparam int DATA_W_DEF          = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 8;

endpackage

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - one-bit 2-flop synchroniser plus debounce FSM
// press is high for the single cycle in which a stable rising level is accepted.
module switch_debounce
  import pp_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic press,
  output logic held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic      sync1;
  logic      synced;
  db_state_t state;
  db_state_t state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      state  <= DB_IDLE;
      cnt    <= '0;
    end else begin
      sync1  <= sw_raw;
      synced <= sync1;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      DB_IDLE: begin
        if (synced) begin
          state_nxt = DB_RISE;
          cnt_nxt   = '0;
        end
      end
      DB_RISE: begin
        if (!synced) begin
          state_nxt = DB_IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = DB_HELD;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DB_HELD: begin
        if (!synced) begin
          state_nxt = DB_FALL;
          cnt_nxt   = '0;
        end
      end
      DB_FALL: begin
        // a short low while held is treated as contact bounce, not a release
        if (synced) begin
          state_nxt = DB_HELD;
        end else if (cnt == CNT_MAX) begin
          state_nxt = DB_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = DB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign held = (state == DB_HELD);

endmodule

// File: rtl/switch_strobe_conditioner.sv
// rtl/switch_strobe_conditioner.sv - debounced switch presses to gated buffer strobes
// Write/read presses become one-cycle strobes unless blocked by full/empty, which are counted.
module switch_strobe_conditioner
  import pp_ctrl_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_write_raw,
  input  logic              sw_read_raw,
  input  logic [DATA_W-1:0] sw_data_raw,
  input  logic              buf_full,
  input  logic              buf_empty,
  output logic              write_en,
  output logic [DATA_W-1:0] write_data,
  output logic              read_en,
  output logic [CNT_W-1:0]  write_reject_cnt,
  output logic [CNT_W-1:0]  read_reject_cnt
);

  logic              wr_press;
  logic              rd_press;
  logic              wr_held_unused;
  logic              rd_held_unused;
  logic [DATA_W-1:0] data_sync1;
  logic [DATA_W-1:0] data_sync2;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_db (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_write_raw),
    .press  (wr_press),
    .held   (wr_held_unused)
  );

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rd_db (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (sw_read_raw),
    .press  (rd_press),
    .held   (rd_held_unused)
  );

  // data switches are only synchronised; they must be settled before the press is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_sync1 <= '0;
      data_sync2 <= '0;
    end else begin
      data_sync1 <= sw_data_raw;
      data_sync2 <= data_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en         <= 1'b0;
      write_data       <= '0;
      write_reject_cnt <= '0;
    end else begin
      write_en <= wr_press && !buf_full;
      if (wr_press && !buf_full) begin
        write_data <= data_sync2;
      end
      if (wr_press && buf_full && (write_reject_cnt != '1)) begin
        write_reject_cnt <= write_reject_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_en         <= 1'b0;
      read_reject_cnt <= '0;
    end else begin
      read_en <= rd_press && !buf_empty;
      if (rd_press && buf_empty && (read_reject_cnt != '1)) begin
        read_reject_cnt <= read_reject_cnt + CNT_W'(1);
      end
    end
  end

endmodule
